// File: rtl/hough_peak_finder_if.sv
// Write side of the peak output FIFO: strobe and data toward the FIFO, full back from it.
interface hough_peak_finder_if #(
    parameter int RHO_RANGE = 512,
    parameter int THETAS    = 180
);
    localparam int OW = 16 + $clog2(RHO_RANGE) + $clog2(THETAS);

    logic          out_wr_en;
    logic          out_full;
    logic [OW-1:0] out_din;

    modport master (output out_wr_en, output out_din, input out_full);
    modport slave  (input out_wr_en, input out_din, output out_full);
endinterface

// File: rtl/hough_peak_finder.sv
// Scans the vote array one cell per cycle into a sorted top-NUM_PEAKS table, then drains it (start to done: RHO_RANGE*THETAS+peaks+2 cycles).
// out_full stalls the drain with no loss; defining HOUGH_PEAK_LOCAL_MAX_EN also requires a 4-connected local maximum.
module hough_peak_finder #(
    parameter int          RHO_RANGE      = 512,
    parameter int          THETAS         = 180,
    parameter int          NUM_PEAKS      = 4,
    parameter logic [15:0] VOTE_THRESHOLD = 16'd20,
    localparam int         RW             = $clog2(RHO_RANGE),
    localparam int         TW             = $clog2(THETAS),
    localparam int         CW             = $clog2(NUM_PEAKS + 1)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [0:RHO_RANGE-1][0:THETAS-1][15:0] accum_buff_in,
    hough_peak_finder_if.master                    out_if,
    output logic                                   busy,
    output logic                                   done,
    output logic [CW-1:0]                          peak_count
);
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    typedef struct packed {
        logic [15:0]   votes;
        logic [RW-1:0] rho;
        logic [TW-1:0] theta;
    } peak_t;

    localparam int IW = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;

    state_t        state_q;
    logic          start_q;
    logic [RW-1:0] rho_q;
    logic [TW-1:0] theta_q;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] peak_count_q;
    logic          busy_q;
    logic          done_q;
    peak_t         tbl_q [NUM_PEAKS];
    peak_t         tbl_d [NUM_PEAKS];

    logic               trig;
    logic               qualify;
    logic               ins;
    logic               wr_en;
    logic               last_theta;
    logic               last_rho;
    logic [15:0]        cell_votes;
    logic [NUM_PEAKS:0] ge;
    peak_t              new_pk;

    assign trig       = start & ~start_q;
    assign cell_votes = accum_buff_in[rho_q][theta_q];
    assign last_theta = (theta_q == TW'(THETAS - 1));
    assign last_rho   = (rho_q == RW'(RHO_RANGE - 1));

`ifdef HOUGH_PEAK_LOCAL_MAX_EN
    logic [15:0] nb_up, nb_dn, nb_lt, nb_rt;

    // Neighbours outside the array read as zero votes.
    always_comb begin
        nb_up = (rho_q != '0)  ? accum_buff_in[rho_q - RW'(1)][theta_q] : 16'd0;
        nb_dn = !last_rho      ? accum_buff_in[rho_q + RW'(1)][theta_q] : 16'd0;
        nb_lt = (theta_q != '0) ? accum_buff_in[rho_q][theta_q - TW'(1)] : 16'd0;
        nb_rt = !last_theta    ? accum_buff_in[rho_q][theta_q + TW'(1)] : 16'd0;
    end

    assign qualify = (cell_votes >= VOTE_THRESHOLD) && (cell_votes >= nb_up) &&
                     (cell_votes >= nb_dn) && (cell_votes >= nb_lt) && (cell_votes >= nb_rt);
`else
    assign qualify = (cell_votes >= VOTE_THRESHOLD);
`endif

    // ge[i+1]: entry i stays put (it ties or beats the cell, so earlier scans win ties).
    always_comb begin
        new_pk.votes = cell_votes;
        new_pk.rho   = rho_q;
        new_pk.theta = theta_q;
        ge[0]        = 1'b1;
        for (int i = 0; i < NUM_PEAKS; i++)
            ge[i+1] = (CW'(i) < cnt_q) && (tbl_q[i].votes >= cell_votes);
        ins   = qualify && !ge[NUM_PEAKS];
        cnt_d = (ins && (cnt_q != CW'(NUM_PEAKS))) ? cnt_q + CW'(1) : cnt_q;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            tbl_d[i] = tbl_q[i];
            if (ins && !ge[i+1])
                tbl_d[i] = ge[i] ? new_pk : tbl_q[(i == 0) ? 0 : i - 1];
        end
    end

    assign wr_en            = (state_q == EMIT) && (idx_q < cnt_q) && !out_if.out_full;
    assign out_if.out_wr_en = wr_en;
    assign out_if.out_din   = wr_en ? tbl_q[idx_q[IW-1:0]] : '0;

    assign busy       = busy_q;
    assign done       = done_q;
    assign peak_count = peak_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            rho_q        <= '0;
            theta_q      <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            peak_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NUM_PEAKS; i++) tbl_q[i] <= '0;
        end else begin
            start_q <= start;
            case (state_q)
                IDLE, DONE: begin
                    if (trig) begin
                        state_q      <= SCAN;
                        rho_q        <= '0;
                        theta_q      <= '0;
                        idx_q        <= '0;
                        cnt_q        <= '0;
                        peak_count_q <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        for (int i = 0; i < NUM_PEAKS; i++) tbl_q[i] <= '0;
                    end
                end
                SCAN: begin
                    for (int i = 0; i < NUM_PEAKS; i++) tbl_q[i] <= tbl_d[i];
                    cnt_q <= cnt_d;
                    if (last_theta) begin
                        theta_q <= '0;
                        if (last_rho) begin
                            state_q <= EMIT;
                            idx_q   <= '0;
                        end else begin
                            rho_q <= rho_q + RW'(1);
                        end
                    end else begin
                        theta_q <= theta_q + TW'(1);
                    end
                end
                EMIT: begin
                    if (idx_q == cnt_q) begin
                        peak_count_q <= cnt_q;
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end else if (wr_en) begin
                        idx_q <= idx_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hough_peak_finder.sv
// Directed and randomized runs of hough_peak_finder against a top-K selection model of the vote array.
module tb_hough_peak_finder;
    localparam int R   = 16;
    localparam int T   = 12;
    localparam int NP  = 4;
    localparam int THR = 20;
    localparam int RW  = $clog2(R);
    localparam int TW  = $clog2(T);
    localparam int OW  = 16 + RW + TW;
    localparam int CW  = $clog2(NP + 1);

    logic                       clock;
    logic                       reset;
    logic                       start;
    logic [0:R-1][0:T-1][15:0]  accum;
    logic                       busy;
    logic                       done;
    logic [CW-1:0]              peak_count;

    hough_peak_finder_if #(.RHO_RANGE(R), .THETAS(T)) fifo_if ();

    hough_peak_finder #(
        .RHO_RANGE(R), .THETAS(T), .NUM_PEAKS(NP), .VOTE_THRESHOLD(16'd20)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .accum_buff_in(accum),
        .out_if(fifo_if), .busy(busy), .done(done), .peak_count(peak_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    logic [OW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit qual(input int r, input int t);
        int v;
        v = int'(accum[r][t]);
        if (v < THR) return 1'b0;
`ifdef HOUGH_PEAK_LOCAL_MAX_EN
        if (r > 0)     if (int'(accum[r-1][t]) > v) return 1'b0;
        if (r < R - 1) if (int'(accum[r+1][t]) > v) return 1'b0;
        if (t > 0)     if (int'(accum[r][t-1]) > v) return 1'b0;
        if (t < T - 1) if (int'(accum[r][t+1]) > v) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Pick the NP strongest qualifying cells; strict '>' in scan order keeps the earliest on ties.
    task automatic build_expected();
        bit taken [R][T];
        int br, bt, bv;
        exp_q.delete();
        for (int r = 0; r < R; r++) for (int t = 0; t < T; t++) taken[r][t] = 1'b0;
        for (int k = 0; k < NP; k++) begin
            br = -1; bt = -1; bv = -1;
            for (int r = 0; r < R; r++)
                for (int t = 0; t < T; t++)
                    if (!taken[r][t] && qual(r, t) && int'(accum[r][t]) > bv) begin
                        bv = int'(accum[r][t]); br = r; bt = t;
                    end
            if (br >= 0) begin
                taken[br][bt] = 1'b1;
                exp_q.push_back({accum[br][bt], RW'(br), TW'(bt)});
            end
        end
    endtask

    task automatic run_case(input string name, input bit stall_en, input bit wiggle,
                            input bit has_first, input logic [OW-1:0] first_exp);
        int c, lat, nbusy, both, wr_full, stall_left, n, exp_lat;
        bit fin;
        logic [OW-1:0] got[$];
        build_expected();
        n = exp_q.size();
        exp_lat = R * T + 2 + n + ((stall_en && n >= 2) ? 10 : 0);
        lat = 0; nbusy = 0; both = 0; wr_full = 0; stall_left = 0; fin = 1'b0;
        @(negedge clock);
        start = 1'b1;
        for (c = 1; c <= R * T + 200 && !fin; c++) begin
            @(posedge clock);
            #1;
            if (wiggle && c == 40) start = 1'b0;
            if (wiggle && c == 41) start = 1'b1;
            fifo_if.out_full = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (busy) nbusy++;
            if (busy && done) both++;
            if (fifo_if.out_wr_en && fifo_if.out_full) wr_full++;
            if (fifo_if.out_wr_en) begin
                got.push_back(fifo_if.out_din);
                if (stall_en && got.size() == 1) stall_left = 10;
            end
            if (done) begin
                fin = 1'b1;
                lat = c;
            end
        end
        check({name, "_done_reached"}, 32'(fin), 32'd1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_cycles"}, nbusy, exp_lat - 1);
        check({name, "_busy_and_done"}, both, 0);
        check({name, "_write_while_full"}, wr_full, 0);
        check({name, "_peak_count"}, 32'(peak_count), n);
        check({name, "_write_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            check($sformatf("%s_peak%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
        if (has_first && got.size() > 0)
            check({name, "_first_entry"}, 32'(got[0]), 32'(first_exp));
        @(negedge clock);
        start = 1'b0;
        fifo_if.out_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check({name, "_done_sticky"}, {30'd0, done, busy}, 32'd2);
        check({name, "_no_write_after_done"}, 32'(fifo_if.out_wr_en), 32'd0);
    endtask

    task automatic put(input int r, input int t, input int v);
        accum[r][t] = 16'(v);
    endtask

    task automatic fill_random(input int ncells, input int vmax);
        int r, t;
        accum = '0;
        for (int k = 0; k < ncells; k++) begin
            r = $urandom_range(R - 1, 0);
            t = $urandom_range(T - 1, 0);
            accum[r][t] = 16'($urandom_range(vmax, 10));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        accum = '0;
        fifo_if.out_full = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_peak_count", 32'(peak_count), 0);
        check("reset_wr_en", 32'(fifo_if.out_wr_en), 0);
        check("reset_din", 32'(fifo_if.out_din), 0);
        @(negedge clock);
        reset = 1'b0;

        accum = '0;
        run_case("all_zero", 1'b0, 1'b0, 1'b0, '0);

        accum = '0;
        put(1, 4, 50); put(9, 10, 80); put(13, 7, 30);
        run_case("three_lines", 1'b0, 1'b1, 1'b1, {16'd80, 4'd9, 4'd10});

        accum = '0;
        put(0, 1, 21); put(2, 3, 22); put(4, 5, 23); put(6, 7, 24); put(8, 9, 25); put(10, 11, 26);
        run_case("six_cells", 1'b0, 1'b0, 1'b1, {16'd26, 4'd10, 4'd11});

        accum = '0;
        put(5, 0, 40); put(6, 0, 40); put(12, 3, 19); put(14, 8, 20);
        run_case("ties_threshold", 1'b0, 1'b0, 1'b1, {16'd40, 4'd5, 4'd0});

        accum = '0;
        put(1, 4, 50); put(9, 10, 80); put(13, 7, 30);
        run_case("full_stall", 1'b1, 1'b0, 1'b1, {16'd80, 4'd9, 4'd10});

        @(negedge clock);
        start = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midscan_reset_busy", 32'(busy), 0);
        check("midscan_reset_done", 32'(done), 0);
        check("midscan_reset_wr_en", 32'(fifo_if.out_wr_en), 0);
        check("midscan_reset_peak_count", 32'(peak_count), 0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        run_case("after_reset", 1'b0, 1'b0, 1'b1, {16'd80, 4'd9, 4'd10});

        accum = '0;
        put(1, 4, 50); put(1, 5, 40);
        run_case("local_max", 1'b0, 1'b0, 1'b1, {16'd50, 4'd1, 4'd4});

        for (int k = 0; k < 6; k++) begin
            fill_random($urandom_range(12, 1), (k == 5) ? 65535 : 45);
            run_case($sformatf("rand_sparse%0d", k), k[0], 1'b0, 1'b0, '0);
        end
        for (int r = 0; r < R; r++)
            for (int t = 0; t < T; t++)
                accum[r][t] = 16'($urandom_range(30, 0));
        run_case("rand_dense", 1'b1, 1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
